dmem_block_copier: RTL and testbench
====================================

// Module: dmem_block_copier
// PURPOSE
//  Initiator for the data-memory port (D_addr/D_rd/D_wr/W_data/R_data); memory is the responder.
//  Copies LEN words from SRC to DST one word at a time: read cycle, then write cycle.
//  Used for block moves and init copies without instruction-level load/store.
//  Shares the memory with the controller through an external arbiter that keys on busy.
// PARAMETERS
//  AW     8   data-memory address width (256 words)
//  DW     16  data word width
//  LEN_W  9   length width; LEN range 0..256
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  src_addr   in   AW     first source word address
//  dst_addr   in   AW     first destination word address
//  len        in   LEN_W  word count
//  busy       out  1      high in READ and WRITE states
//  done       out  1      one-cycle completion pulse
//  D_addr     out  AW     memory address
//  D_rd       out  1      memory read enable; R_data is combinational when high
//  D_wr       out  1      memory write enable; memory writes at posedge
//  W_data     out  DW     write data
//  R_data     in   DW     read data from memory
//  checksum   out  DW     only with the macro; see CONFIGURATION
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; busy, done, D_rd, D_wr = 0; D_addr, W_data, checksum = 0.
//   Internal count, buffer and latched addresses are also cleared.
//  FSM: IDLE -> READ -> WRITE -> (READ | DONE) -> IDLE. Outputs decode from the state register only (Moore).
//  IDLE: on posedge with start=1, latch src_addr, dst_addr, len; clear count i.
//   len=0 -> DONE, else -> READ. Inputs are don't-care after latching.
//  READ: D_rd=1; D_addr = src+i, mod 2^AW (wraps 0xFF->0x00).
//   On posedge: buf <= R_data; -> WRITE.
//  WRITE: D_wr=1; D_addr = dst+i, mod 2^AW; W_data = buf.
//   On posedge: i <= i+1. If i+1 == len -> DONE, else -> READ.
//  DONE: done=1 for exactly one cycle, busy=0; -> IDLE.
//  Idle-state outputs: D_rd=0, D_wr=0, D_addr=0, W_data=0. D_rd and D_wr are never both high.
//  Latency: start edge to done high is 2*len+1 cycles (len=0: 1 cycle).
//  start while busy or in DONE is ignored (not queued).
//  Overlap: copy is strictly ascending. Overlapping regions with dst>src get forward-copy semantics
//   (earlier written words are re-read). This is defined behaviour, not an error.
//  len=256 copies the whole memory; the count uses LEN_W bits, so there is no overflow.
//  Reset mid-copy: abort immediately, no done pulse. Words already written stay in memory.
// CONFIGURATION
//  DMEM_COPY_CHECKSUM_EN defined: checksum port present.
//   Cleared to 0 on accepted start. In WRITE, at posedge: checksum <= checksum + buf, mod 2^DW.
//   Valid from the done pulse until the next accepted start.
//  Not defined: no checksum port, no accumulator logic. All other behaviour is identical.
// TESTING
//  1) mem[0x10..0x13]=1,2,3,4; start src=0x10 dst=0x40 len=4
//     -> mem[0x40..0x43]=1,2,3,4; done 9 cycles after start edge; busy high 8 cycles.
//  2) len=0, start -> done next cycle; D_rd and D_wr never asserted; memory unchanged.
//  3) src=0xFE dst=0x20 len=4, mem[FE,FF,00,01]=A,B,C,D
//     -> mem[20..23]=A,B,C,D; D_addr sequence FE,20,FF,21,00,22,01,23.
//  4) start pulsed again during copy of test 1 with other args -> ignored; one done; only 0x40..0x43 written.
//  5) reset=0 after 2nd write of test 1 -> outputs zero at once; mem[0x40,0x41] written, mem[0x42] untouched; no done.
//  6) with DMEM_COPY_CHECKSUM_EN, test 1 -> checksum=10 at done. Words 0xFFFF,0x0002 -> checksum=0x0001.

Source files
------------

// File: rtl/dmem_block_copier_if.sv
// Data-memory port between the block copier (master) and the memory (slave).
// R_data is combinational from the memory while D_rd is high; writes land at the rising edge.
interface dmem_block_copier_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] D_addr;
    logic          D_rd;
    logic          D_wr;
    logic [DW-1:0] W_data;
    logic [DW-1:0] R_data;

    modport master (
        output D_addr,
        output D_rd,
        output D_wr,
        output W_data,
        input  R_data
    );

    modport slave (
        input  D_addr,
        input  D_rd,
        input  D_wr,
        input  W_data,
        output R_data
    );
endinterface

// File: rtl/dmem_block_copier.sv
// Word-by-word block copier on the data-memory port: one read cycle, then one write cycle per word.
// Optional running checksum of copied words is enabled by defining DMEM_COPY_CHECKSUM_EN.
module dmem_block_copier #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    src_addr,
    input  logic [AW-1:0]    dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg,
    dmem_block_copier_if.master mem
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0]    checksum
`endif
);

    // Request protocol: start is a level sampled only in IDLE; once accepted, busy stays
    // high for the READ/WRITE phase, and done pulses for one cycle afterwards.
    // A start seen while busy or during the done cycle is dropped, never queued.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_next;

    assign cnt_next  = cnt + LEN_W'(1);
    assign state_dbg = state;

    // W_data doubles as the word buffer: it captures R_data at the end of READ and is
    // only presented to memory while D_wr is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem.D_addr <= '0;
            mem.D_rd   <= 1'b0;
            mem.D_wr   <= 1'b0;
            mem.W_data <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len;
                        cnt   <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= READ;
                            busy       <= 1'b1;
                            mem.D_rd   <= 1'b1;
                            mem.D_addr <= src_addr;
                        end
                    end
                end
                READ: begin
                    state      <= WRITE;
                    mem.W_data <= mem.R_data;
                    mem.D_rd   <= 1'b0;
                    mem.D_wr   <= 1'b1;
                    mem.D_addr <= dst_q + cnt[AW-1:0];
                end
                WRITE: begin
                    cnt        <= cnt_next;
                    mem.D_wr   <= 1'b0;
                    mem.W_data <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
                    checksum   <= checksum + mem.W_data;
`endif
                    if (cnt_next == len_q) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        mem.D_addr <= '0;
                    end else begin
                        state      <= READ;
                        mem.D_rd   <= 1'b1;
                        mem.D_addr <= src_q + cnt_next[AW-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    mem.D_rd   <= 1'b0;
                    mem.D_wr   <= 1'b0;
                    mem.D_addr <= '0;
                    mem.W_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_block_copier.sv
// Bench for dmem_block_copier: directed cases plus randomized copies checked against an array model.
// Define DMEM_COPY_CHECKSUM_EN to also check the checksum port.
module tb_dmem_block_copier;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LEN_W = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    src_addr;
    logic [AW-1:0]    dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [DW-1:0]    checksum;
`endif

    int vectors    = 0;
    int miscompares = 0;

    dmem_block_copier_if #(.AW(AW), .DW(DW)) bus ();

    dmem_block_copier #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .mem       (bus)
`ifdef DMEM_COPY_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // clock
    always #5 clk = ~clk;

    // memory responder and reference image
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    assign bus.R_data = bus.D_rd ? ram[bus.D_addr] : '0;

    always @(posedge clk) begin
        if (bus.D_wr) ram[bus.D_addr] = bus.W_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== ref_mem[a]) bad++;
        check({tag, " mem_words_wrong"}, bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},   busy,       1'b0);
        check({tag, " done"},   done,       1'b0);
        check({tag, " D_rd"},   bus.D_rd,   1'b0);
        check({tag, " D_wr"},   bus.D_wr,   1'b0);
        check({tag, " D_addr"}, bus.D_addr, 8'h00);
        check({tag, " W_data"}, bus.W_data, 16'h0000);
    endtask

    // Called at posedge+1; issues one copy and checks timing, address order, memory and checksum.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                            input int interfere_at, input string tag);
        logic [7:0]    exp_addr[$];
        logic [7:0]    got_addr[$];
        logic [DW-1:0] exp_sum;
        int            edges;
        int            busy_cycles;
        int            extra_done;
        logic          both;
        exp_sum = '0;
        for (int k = 0; k < n; k++) begin
            logic [7:0] sa;
            logic [7:0] da;
            sa = s + 8'(k);
            da = d + 8'(k);
            exp_addr.push_back(sa);
            exp_addr.push_back(da);
            exp_sum     = exp_sum + ref_mem[sa];
            ref_mem[da] = ref_mem[sa];
        end
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        edges = 0; busy_cycles = 0; both = 1'b0;
        while (edges < 2 * int'(n) + 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                start = 1'b0; src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 9'($urandom);
            end
            if (interfere_at > 0 && edges == interfere_at) begin
                start = 1'b1; src_addr = 8'h80; dst_addr = 8'h90; len = 9'd3;
            end
            if (interfere_at > 0 && edges == interfere_at + 1) start = 1'b0;
            if (bus.D_rd && bus.D_wr) both = 1'b1;
            if (bus.D_rd || bus.D_wr) got_addr.push_back(bus.D_addr);
            if (busy) busy_cycles++;
            if (done) break;
        end
        check({tag, " done_latency"}, edges, 2 * int'(n) + 1);
        check({tag, " busy_cycles"}, busy_cycles, 2 * int'(n));
        check({tag, " rd_wr_overlap"}, both, 1'b0);
        check({tag, " addr_count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
`ifdef DMEM_COPY_CHECKSUM_EN
        check({tag, " checksum"}, checksum, exp_sum);
`endif
        extra_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check({tag, " extra_done"}, extra_done, 0);
        check_idle_outputs({tag, " after"});
        check_mem(tag);
    endtask

    initial begin
        int bad;
        reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        for (int a = 0; a < 256; a++) poke(8'(a), 16'($urandom));
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef DMEM_COPY_CHECKSUM_EN
        check("reset checksum", checksum, 16'h0000);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;

        // basic four-word copy
        for (int k = 0; k < 4; k++) poke(8'h10 + 8'(k), 16'(k + 1));
        run_copy(8'h10, 8'h40, 9'd4, 0, "t1");
`ifdef DMEM_COPY_CHECKSUM_EN
        check("t1 checksum_const", checksum, 16'd10);
`endif
        for (int k = 0; k < 4; k++)
            check($sformatf("t1 dst[%0d]", k), ram[8'h40 + 8'(k)], 16'(k + 1));

        // zero length
        run_copy(8'h33, 8'h55, 9'd0, 0, "t2");

        // source wraps past the top of memory
        poke(8'hFE, 16'h000A); poke(8'hFF, 16'h000B); poke(8'h00, 16'h000C); poke(8'h01, 16'h000D);
        run_copy(8'hFE, 8'h20, 9'd4, 0, "t3");

        // start re-pulsed mid-copy with other arguments
        for (int k = 0; k < 4; k++) poke(8'h10 + 8'(k), 16'(k + 5));
        run_copy(8'h10, 8'h40, 9'd4, 3, "t4");

        // reset after the second write
        for (int k = 0; k < 4; k++) poke(8'h10 + 8'(k), 16'(k + 9));
        poke(8'h42, 16'hBEEF);
        start = 1'b1; src_addr = 8'h10; dst_addr = 8'h40; len = 9'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_idle_outputs("t5 abort");
        ref_mem[8'h40] = ref_mem[8'h10];
        ref_mem[8'h41] = ref_mem[8'h11];
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done) bad++;
        end
        check("t5 done_in_reset", bad, 0);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done) bad++;
        end
        check("t5 done_after_reset", bad, 0);
        check("t5 mem42", ram[8'h42], 16'hBEEF);
        check_mem("t5");

        // checksum wrap case
        poke(8'h60, 16'hFFFF); poke(8'h61, 16'h0002);
        run_copy(8'h60, 8'h70, 9'd2, 0, "t6");
`ifdef DMEM_COPY_CHECKSUM_EN
        check("t6 checksum_const", checksum, 16'h0001);
`endif

        // overlapping forward copy
        run_copy(8'h00, 8'h02, 9'd8, 0, "t7");

        // randomized copies
        for (int r = 0; r < 8; r++)
            run_copy(8'($urandom), 8'($urandom), 9'($urandom_range(1, 24)), 0, $sformatf("rnd%0d", r));

        // full-memory copy
        run_copy(8'($urandom), 8'($urandom), 9'd256, 0, "full");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
